// File: rtl/md_sequencer.sv
// Multi-cycle multiply/divide sequencer for the E stage: latches operands, counts down the op
// latency, then commits the product or quotient/remainder into HI/LO.
module md_sequencer #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] operand1,
  input  logic [31:0] operand2,
  input  logic        d_md_use,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam int MAX_LAT = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW      = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  logic [0:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    op_q, op_d;
  logic [31:0]   a_q, a_d;
  logic [31:0]   b_q, b_d;
  logic [31:0]   hi_q, hi_d;
  logic [31:0]   lo_q, lo_d;

  logic        start_md;
  logic [63:0] prod_s, prod_u;
  logic        a_neg, b_neg;
  logic [31:0] abs_a, abs_b, div_b, uq, ur, quot, rem;

  assign start_md = start && (op >= OP_MULT) && (op <= OP_DIVU);
  assign busy     = (state_q == ST_RUN);
  assign md_stall = d_md_use && (start_md || busy);
  assign hi       = hi_q;
  assign lo       = lo_q;

  assign prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
  assign prod_u = {32'd0, a_q} * {32'd0, b_q};

  // Signed division on magnitudes avoids the 0x80000000 / -1 overflow case of native signed divide.
  assign a_neg = (op_q == OP_DIV) && a_q[31];
  assign b_neg = (op_q == OP_DIV) && b_q[31];
  assign abs_a = a_neg ? -a_q : a_q;
  assign abs_b = b_neg ? -b_q : b_q;
  assign div_b = (abs_b == 32'd0) ? 32'd1 : abs_b;
  assign uq    = abs_a / div_b;
  assign ur    = abs_a % div_b;
  assign quot  = (a_neg ^ b_neg) ? -uq : uq;
  assign rem   = a_neg ? -ur : ur;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    if (state_q == ST_IDLE) begin
      if (start_md) begin
        state_d = ST_RUN;
        op_d    = op;
        a_d     = operand1;
        b_d     = operand2;
        cnt_d   = (op <= OP_MULTU) ? CW'(MULT_CYCLES - 1) : CW'(DIV_CYCLES - 1);
      end else if (start && op == OP_MTHI) begin
        hi_d = operand1;
      end else if (start && op == OP_MTLO) begin
        lo_d = operand1;
      end
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end else begin
      state_d = ST_IDLE;
      case (op_q)
        OP_MULT:  {hi_d, lo_d} = prod_s;
        OP_MULTU: {hi_d, lo_d} = prod_u;
        default: begin
          // Division by zero leaves HI/LO untouched.
          if (b_q != 32'd0) begin
            hi_d = rem;
            lo_d = quot;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

endmodule

// File: tb/tb_md_sequencer.sv
// Directed bench for md_sequencer: expected {hi,lo} pushed at issue, popped and compared at commit.
module tb_md_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] operand1, operand2;
  logic        d_md_use;
  logic        busy, md_stall;
  logic [31:0] hi, lo;

  int checks = 0;
  int failures = 0;
  logic [63:0] exp_q[$];
  logic [31:0] m_hi, m_lo;

  md_sequencer #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .operand1(operand1), .operand2(operand2), .d_md_use(d_md_use),
    .busy(busy), .md_stall(md_stall), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Issue one mult/div op and follow it to commit; optionally inject a second MULT mid-run.
  task automatic run_md(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input int lat, input logic use_d,
                        input logic inject, input logic [63:0] expv);
    int n;
    logic [63:0] e;
    exp_q.push_back(expv);
    @(negedge clk);
    start = 1'b1; op = o; operand1 = a; operand2 = b; d_md_use = use_d;
    #1;
    check({tag, "_stall_start"}, {63'd0, md_stall}, {63'd0, use_d});
    @(negedge clk);
    start = 1'b0; op = 3'd0;
    n = 0;
    while (busy === 1'b1 && n < 50) begin
      check({tag, "_stall_busy"}, {63'd0, md_stall}, {63'd0, use_d});
      check({tag, "_hold"}, {hi, lo}, {m_hi, m_lo});
      n++;
      operand1 = $urandom; operand2 = $urandom;
      if (inject && n == 1) begin
        start = 1'b1; op = 3'd1; operand1 = 32'd5; operand2 = 32'd7;
      end else begin
        start = 1'b0; op = 3'd0;
      end
      @(negedge clk);
    end
    start = 1'b0; op = 3'd0;
    check({tag, "_busy_cycles"}, 64'(n), 64'(lat));
    e = exp_q.pop_front();
    check({tag, "_result"}, {hi, lo}, e);
    check({tag, "_stall_after"}, {63'd0, md_stall}, 64'd0);
    $display("txn %s op=%0d a=%h b=%h busy=%0d hi=%h lo=%h", tag, o, a, b, n, hi, lo);
    {m_hi, m_lo} = e;
    d_md_use = 1'b0;
  endtask

  task automatic move(input logic [2:0] o, input logic [31:0] v);
    @(negedge clk);
    start = 1'b1; op = o; operand1 = v; d_md_use = 1'b1;
    #1;
    check("mt_stall", {63'd0, md_stall}, 64'd0);
    @(negedge clk);
    start = 1'b0; op = 3'd0; d_md_use = 1'b0;
    check("mt_busy", {63'd0, busy}, 64'd0);
    if (o == 3'd5) m_hi = v; else m_lo = v;
    $display("txn mt op=%0d v=%h hi=%h lo=%h", o, v, hi, lo);
  endtask

  initial begin
    logic [31:0] ra, rb;
    reset = 1'b1; start = 1'b0; op = 3'd0; operand1 = '0; operand2 = '0; d_md_use = 1'b1;
    m_hi = '0; m_lo = '0;
    #2;
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_hilo", {hi, lo}, 64'd0);
    check("rst_stall", {63'd0, md_stall}, 64'd0);
    @(negedge clk);
    reset = 1'b0; d_md_use = 1'b0;

    move(3'd5, 32'hDEADBEEF);
    move(3'd6, 32'h00001234);
    check("mt_hilo", {hi, lo}, {32'hDEADBEEF, 32'h00001234});

    run_md("mult", 3'd1, 32'hFFFFFFFE, 32'd3, 5, 1'b1, 1'b1, {32'hFFFFFFFF, 32'hFFFFFFFA});
    run_md("multu", 3'd2, 32'hFFFFFFFE, 32'd3, 5, 1'b0, 1'b0, {32'h00000002, 32'hFFFFFFFA});
    run_md("div_neg", 3'd3, 32'hFFFFFFF9, 32'd2, 10, 1'b1, 1'b0, {32'hFFFFFFFF, 32'hFFFFFFFD});
    run_md("div_ovf", 3'd3, 32'h80000000, 32'hFFFFFFFF, 10, 1'b0, 1'b0, {32'h0, 32'h80000000});

    move(3'd5, 32'h11);
    move(3'd6, 32'h22);
    run_md("divu_z", 3'd4, 32'd100, 32'd0, 10, 1'b1, 1'b0, {32'h11, 32'h22});

    for (int i = 0; i < 3; i++) begin
      ra = $urandom; rb = $urandom_range(1, 65535);
      run_md("divu_rnd", 3'd4, ra, rb, 10, 1'b0, 1'b0, {ra % rb, ra / rb});
    end

    // op 0 and 7 must be ignored
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      start = 1'b1; op = (k == 0) ? 3'd0 : 3'd7; operand1 = 32'hA5A5A5A5; d_md_use = 1'b1;
      #1;
      check("nop_stall", {63'd0, md_stall}, 64'd0);
      @(negedge clk);
      start = 1'b0; d_md_use = 1'b0;
      check("nop_busy", {63'd0, busy}, 64'd0);
      check("nop_hilo", {hi, lo}, {m_hi, m_lo});
      $display("txn nop op=%0d hi=%h lo=%h", op, hi, lo);
    end

    // Asynchronous reset during the fourth busy cycle of a DIV
    @(negedge clk);
    start = 1'b1; op = 3'd3; operand1 = 32'd1000; operand2 = 32'd7;
    @(negedge clk);
    start = 1'b0; op = 3'd0; d_md_use = 1'b1;
    repeat (3) @(negedge clk);
    check("rr_busy_pre", {63'd0, busy}, 64'd1);
    #2 reset = 1'b1;
    #1;
    check("rr_busy", {63'd0, busy}, 64'd0);
    check("rr_hilo", {hi, lo}, 64'd0);
    check("rr_stall", {63'd0, md_stall}, 64'd0);
    $display("txn reset_mid_div busy=%0d hi=%h lo=%h", busy, hi, lo);
    @(negedge clk);
    reset = 1'b0; d_md_use = 1'b0;
    repeat (12) @(negedge clk);
    check("rr_idle", {31'd0, busy, hi}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
